// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - state encoding and constants shared by the SPI transaction arbiter
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4
  } state_e;

  localparam int SPI_BITS = 8;
  localparam logic [1:0] SLAVE_INVALID = 2'b11;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin find-first-set over req, starting at ptr and wrapping
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               found
);

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sharing of one SPI master, one timed 8-bit transfer per grant
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_slave,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rx_data,
  output logic                   busy,
  output logic                   m_start,
  output logic [1:0]             m_slave_select,
  output logic [7:0]             m_data_to_send,
  input  logic [7:0]             m_data_received,
  output logic                   m_reset
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SPI_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 busy_q, busy_d;
  logic                 m_start_q, m_start_d;
  logic [1:0]           m_slave_select_q, m_slave_select_d;
  logic [7:0]           m_data_to_send_q, m_data_to_send_d;

  logic [NUM_REQ-1:0]   pick_req;
  logic [PTR_W-1:0]     pick_winner;
  logic                 pick_found;
  logic [PTR_W-1:0]     pick_next;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [1:0]           pick_slave;
  logic [7:0]           pick_data;

  // A requester that was just rejected still shows req for one cycle; mask it.
  assign pick_req = req & ~err_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req    (pick_req),
    .ptr    (rr_ptr_q),
    .winner (pick_winner),
    .found  (pick_found)
  );

  assign pick_next   = PTR_W'(wrap_inc(int'(pick_winner), NUM_REQ));
  assign pick_onehot = NUM_REQ'(1) << pick_winner;
  assign pick_slave  = req_slave[2*pick_winner +: 2];
  assign pick_data   = req_data[8*pick_winner +: 8];

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    cnt_d            = cnt_q;
    gnt_d            = '0;
    done_d           = '0;
    err_d            = '0;
    rx_data_d        = rx_data_q;
    busy_d           = busy_q;
    m_start_d        = 1'b0;
    m_slave_select_d = m_slave_select_q;
    m_data_to_send_d = m_data_to_send_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pick_found) begin
          rr_ptr_d = pick_next;
          if (pick_slave == SLAVE_INVALID) begin
            err_d = pick_onehot;
          end else begin
            gnt_d            = pick_onehot;
            owner_d          = pick_winner;
            m_start_d        = 1'b1;
            m_slave_select_d = pick_slave;
            m_data_to_send_d = pick_data;
            busy_d           = 1'b1;
            state_d          = START;
          end
        end
      end
      START: begin
        cnt_d   = CNT_ONE;
        state_d = SHIFT;
      end
      // The master has no done flag, so the transfer length is timed here.
      SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SHIFT_LAST) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rx_data_d = m_data_received;
        done_d    = NUM_REQ'(1) << owner_q;
        cnt_d     = '0;
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      cnt_q            <= '0;
      gnt_q            <= '0;
      done_q           <= '0;
      err_q            <= '0;
      rx_data_q        <= '0;
      busy_q           <= 1'b0;
      m_start_q        <= 1'b0;
      m_slave_select_q <= '0;
      m_data_to_send_q <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      owner_q          <= owner_d;
      cnt_q            <= cnt_d;
      gnt_q            <= gnt_d;
      done_q           <= done_d;
      err_q            <= err_d;
      rx_data_q        <= rx_data_d;
      busy_q           <= busy_d;
      m_start_q        <= m_start_d;
      m_slave_select_q <= m_slave_select_d;
      m_data_to_send_q <= m_data_to_send_d;
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rx_data        = rx_data_q;
  assign busy           = busy_q;
  assign m_start        = m_start_q;
  assign m_slave_select = m_slave_select_q;
  assign m_data_to_send = m_data_to_send_q;
  assign m_reset        = ~reset;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - randomized bench for spi_txn_arbiter against a transaction-schedule model
module tb_spi_txn_arbiter;

  localparam int N    = 3;
  localparam int GAP  = 2;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             reset;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_slave;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     gnt, done, err;
  logic [7:0]       rx_data;
  logic             busy, m_start;
  logic [1:0]       m_slave_select;
  logic [7:0]       m_data_to_send;
  logic [7:0]       m_data_received;
  logic             m_reset;

  logic [1:0]  r0_req, r0_gnt, r0_done, r0_err;
  logic [3:0]  r0_slave;
  logic [15:0] r0_data;
  logic [7:0]  r0_rx, r0_dts, r0_mdr;
  logic        r0_busy, r0_start, r0_mreset;
  logic [1:0]  r0_ss;

  spi_txn_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_slave(req_slave), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rx_data(rx_data), .busy(busy), .m_start(m_start),
    .m_slave_select(m_slave_select), .m_data_to_send(m_data_to_send),
    .m_data_received(m_data_received), .m_reset(m_reset)
  );

  spi_txn_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0)) u_dut_gap0 (
    .clk(clk), .reset(reset), .req(r0_req), .req_slave(r0_slave), .req_data(r0_data),
    .gnt(r0_gnt), .done(r0_done), .err(r0_err), .rx_data(r0_rx), .busy(r0_busy), .m_start(r0_start),
    .m_slave_select(r0_ss), .m_data_to_send(r0_dts),
    .m_data_received(r0_mdr), .m_reset(r0_mreset)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Requester intent and slave behaviour
  logic [N-1:0] want;
  logic [1:0]   w_slave [N];
  logic [7:0]   w_data  [N];
  logic [7:0]   resp_tab [4];

  // Expected per-cycle outputs, indexed by cycle number
  logic [N-1:0] e_gnt [MAXC];
  logic [N-1:0] e_done[MAXC];
  logic [N-1:0] e_err [MAXC];
  logic [7:0]   e_rx  [MAXC];
  logic [1:0]   e_ss  [MAXC];
  logic [7:0]   e_dt  [MAXC];
  logic         e_busy[MAXC];
  int           m_ptr, m_free;
  logic [1:0]   cur_ss;
  logic [7:0]   cur_dt, cur_rx;

  // Behavioural SPI master with a slave that answers resp_tab[select]
  int         mr_bits = 8;
  logic [7:0] mr_src  = 8'h00;
  always @(posedge clk) begin
    if (reset && m_start) begin
      mr_src  = resp_tab[m_slave_select];
      mr_bits = 0;
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      mr_bits = 8;
    end else if (mr_bits < 8) begin
      m_data_received = {m_data_received[6:0], mr_src[7-mr_bits]};
      mr_bits++;
    end
  end

  task automatic clear_from(input int c);
    for (int j = c; j < MAXC; j++) begin
      e_gnt[j] = '0; e_done[j] = '0; e_err[j] = '0; e_rx[j] = '0;
      e_ss[j] = '0; e_dt[j] = '0; e_busy[j] = 1'b0;
    end
  endtask

  task automatic model_reset();
    clear_from(cyc);
    m_ptr = 0; m_free = MAXC;
    cur_ss = '0; cur_dt = '0; cur_rx = '0;
  endtask

  // Schedule the consequences of an arbitration at edge e
  task automatic model_edge(input int e);
    int w;
    logic [1:0] s;
    if (e < m_free || e + 20 >= MAXC) return;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    if (w < 0) return;
    m_ptr = (w + 1) % N;
    s = req_slave[2*w +: 2];
    if (s == 2'b11) begin
      e_err[e] = N'(1) << w;
    end else begin
      e_gnt[e] = N'(1) << w;
      e_ss[e] = s;
      e_dt[e] = req_data[8*w +: 8];
      e_done[e+9] = N'(1) << w;
      e_rx[e+9] = resp_tab[s];
      for (int j = e; j <= e + 8 + GAP; j++) e_busy[j] = 1'b1;
      m_free = e + 10 + GAP;
    end
  endtask

  task automatic check_cycle();
    if (e_gnt[cyc] != '0) begin cur_ss = e_ss[cyc]; cur_dt = e_dt[cyc]; end
    if (e_done[cyc] != '0) cur_rx = e_rx[cyc];
    check_eq("gnt", 32'(gnt), 32'(e_gnt[cyc]));
    check_eq("done", 32'(done), 32'(e_done[cyc]));
    check_eq("err", 32'(err), 32'(e_err[cyc]));
    check_eq("busy", 32'(busy), 32'(e_busy[cyc]));
    check_eq("m_start", 32'(m_start), 32'(e_gnt[cyc] != '0));
    check_eq("m_slave_select", 32'(m_slave_select), 32'(cur_ss));
    check_eq("m_data_to_send", 32'(m_data_to_send), 32'(cur_dt));
    check_eq("rx_data", 32'(rx_data), 32'(cur_rx));
    check_eq("m_reset", 32'(m_reset), 32'(!reset));
  endtask

  task automatic drive();
    req = want;
    for (int i = 0; i < N; i++) begin
      req_slave[2*i +: 2] = w_slave[i];
      req_data[8*i +: 8]  = w_data[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc + 20 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    check_cycle();
    for (int i = 0; i < N; i++) if (gnt[i] || err[i]) want[i] = 1'b0;
    drive();
    if (reset) model_edge(cyc + 1);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    drive();
    m_free = cyc + 1;
    model_edge(cyc + 1);
  endtask

  int order[$];
  int exp_ord[4] = '{0, 1, 2, 0};
  int n0, seen, g0cnt;
  int g_c[$], g_i[$], d_c[$];

  initial begin
    reset = 1'b0; want = '0; m_data_received = 8'h00;
    for (int i = 0; i < N; i++) begin w_slave[i] = 2'b00; w_data[i] = 8'h00; end
    for (int s = 0; s < 4; s++) resp_tab[s] = 8'(8'h10 + s);
    r0_req = '0; r0_slave = 4'b10_00; r0_data = 16'h77_66; r0_mdr = 8'h5A;
    drive();
    model_reset();
    repeat (3) tick();
    release_reset();

    // Single request, slave 1 answering 8'h3C
    resp_tab[1] = 8'h3C;
    want[1] = 1'b1; w_slave[1] = 2'b01; w_data[1] = 8'hA5;
    repeat (20) tick();

    // Simultaneous requests from reset; requester 0 asks again after its grant
    reset = 1'b0; model_reset();
    repeat (2) tick();
    want = 3'b111;
    w_slave[0] = 2'b00; w_data[0] = 8'h12;
    w_slave[1] = 2'b01; w_data[1] = 8'h34;
    w_slave[2] = 2'b10; w_data[2] = 8'h56;
    release_reset();
    n0 = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
      if (gnt[0] && n0 == 0) begin n0++; want[0] = 1'b1; end
    end
    check_eq("order_len", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) if (k < order.size()) check_eq("order", 32'(order[k]), 32'(exp_ord[k]));

    // Invalid slave select, then two requesters race
    want[2] = 1'b1; w_slave[2] = 2'b11;
    repeat (3) tick();
    want[0] = 1'b1; want[1] = 1'b1;
    repeat (40) tick();

    // Reset while shifting (counter 4)
    for (int s = 0; s < 4; s++) resp_tab[s] = 8'($urandom);
    want[1] = 1'b1; w_slave[1] = 2'b10; w_data[1] = 8'hC3;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      tick();
      if (gnt[1]) seen = 1;
    end
    check_eq("gnt_wait", 32'(seen), 32'd1);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_outputs", {gnt, done, err, rx_data, busy, m_start, m_slave_select, m_data_to_send}, 32'd0);
    check_eq("rst_m_reset", 32'(m_reset), 32'd1);
    model_reset();
    repeat (3) tick();
    want[2] = 1'b1; w_slave[2] = 2'b00; w_data[2] = 8'h9E;
    release_reset();
    repeat (25) tick();

    // Withdrawal while busy; a held request is served at the first idle cycle
    want[2] = 1'b1; w_slave[2] = 2'b01;
    repeat (3) tick();
    want[0] = 1'b1; w_slave[0] = 2'b00;
    tick();
    want[0] = 1'b0;
    want[1] = 1'b1; w_slave[1] = 2'b10;
    g0cnt = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (gnt[0]) g0cnt++;
    end
    check_eq("withdrawn_gnt", 32'(g0cnt), 32'd0);

    // Random traffic
    for (int s = 0; s < 4; s++) resp_tab[s] = 8'($urandom);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1;
          w_slave[i] = 2'($urandom_range(0, 3));
          w_data[i] = 8'($urandom);
        end else if (want[i] && $urandom_range(0, 15) == 0) begin
          want[i] = 1'b0;
        end
      end
      tick();
    end
    want = '0;
    repeat (30) tick();

    // GAP_CYCLES = 0: back-to-back requests
    @(negedge clk);
    r0_req = 2'b11;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (r0_gnt != 2'b00) begin
        g_c.push_back(cyc);
        g_i.push_back(r0_gnt[1] ? 1 : 0);
        check_eq("g0_ss", 32'(r0_ss), r0_gnt[1] ? 32'd2 : 32'd0);
        check_eq("g0_dts", 32'(r0_dts), r0_gnt[1] ? 32'h77 : 32'h66);
        check_eq("g0_busy", 32'(r0_busy), 32'd1);
        check_eq("g0_start", 32'(r0_start), 32'd1);
        r0_req = r0_req & ~r0_gnt;
      end
      if (r0_done != 2'b00) begin
        d_c.push_back(cyc);
        check_eq("g0_rx", 32'(r0_rx), 32'h5A);
      end
      check_eq("g0_err", 32'(r0_err), 32'd0);
    end
    check_eq("g0_mreset", 32'(r0_mreset), 32'd0);
    check_eq("g0_gnt_count", 32'(g_c.size()), 32'd2);
    check_eq("g0_done_count", 32'(d_c.size()), 32'd2);
    if (g_c.size() >= 2 && d_c.size() >= 2) begin
      check_eq("g0_first", 32'(g_i[0]), 32'd0);
      check_eq("g0_second", 32'(g_i[1]), 32'd1);
      check_eq("g0_lat1", 32'(d_c[0] - g_c[0]), 32'd9);
      check_eq("g0_back2back", 32'(g_c[1] - d_c[0]), 32'd1);
      check_eq("g0_lat2", 32'(d_c[1] - g_c[1]), 32'd9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
